// File: rtl/dram_responder_if.sv
// DRAM request/response bundle between the bus arbiter (master) and the responder (slave).
// Carries no state of its own; timing is owned by the responder.
// Backpressure is the busy level: le is ignored while busy is high. Macro: DRAM_RESP_PERF_CNT_EN.
interface dram_responder_if;
    logic        w_dram_le;
    logic [31:0] w_dram_addr;
    logic [31:0] w_dram_wdata;
    logic        w_dram_we_t;
    logic [2:0]  w_dram_ctrl;
    logic [31:0] w_dram_odata;
    logic        w_dram_busy;
    logic        w_dram_err;
`ifdef DRAM_RESP_PERF_CNT_EN
    logic [31:0] w_dram_rd_cnt;
    logic [31:0] w_dram_wr_cnt;
`endif

    modport master (
        output w_dram_le, w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_ctrl,
        input  w_dram_odata, w_dram_busy, w_dram_err
`ifdef DRAM_RESP_PERF_CNT_EN
        , w_dram_rd_cnt, w_dram_wr_cnt
`endif
    );

    modport slave (
        input  w_dram_le, w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_ctrl,
        output w_dram_odata, w_dram_busy, w_dram_err
`ifdef DRAM_RESP_PERF_CNT_EN
        , w_dram_rd_cnt, w_dram_wr_cnt
`endif
    );
endinterface

// File: rtl/dram_responder.sv
// DRAM stand-in: one request per le strobe against a 2**ADDR_W x 32 synchronous word array.
// Latency: busy high for LATENCY cycles after le; result and busy=0 appear together after that.
// Backpressure: le is ignored while busy (no queue); a new le is taken the first cycle busy is low.
// Optional: DRAM_RESP_PERF_CNT_EN adds successful load/store completion counters.
module dram_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 4
) (
    input  logic             CLK,
    input  logic             RST,
    dram_responder_if.slave  bus
);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              accept, complete;

    // Latched request
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [2:0]        r_ctrl;

    // Decoded request
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic              ld_done, st_done;

    // Array and load return path
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rd_word;
    logic [2:0]        ld_ctrl;
    logic [1:0]        ld_off;
    logic              ld_zero;
    logic              err_q;
    logic [7:0]        rd_b;
    logic [15:0]       rd_h;
    logic [31:0]       ld_val;

    // Address bits above the array index are ignored by design.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.w_dram_addr[31:ADDR_W+2]};

    // State and countdown register; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: accept in IDLE, count down in ACCESS, complete when cnt hits 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.w_dram_le) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 8'd0) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request fields on acceptance; held stable for the whole access.
    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            r_idx   <= bus.w_dram_addr[ADDR_W+1:2];
            r_off   <= bus.w_dram_addr[1:0];
            r_wdata <= bus.w_dram_wdata;
            r_we    <= bus.w_dram_we_t;
            r_ctrl  <= bus.w_dram_ctrl;
        end
    end

    // Size decode: byte enables, replicated store lanes and misalignment/illegal-code error.
    always_comb begin
        req_err = 1'b0;
        be      = 4'b0000;
        wlane   = r_wdata;
        case (r_ctrl)
            3'b000, 3'b100: begin
                be      = 4'b0001 << r_off;
                wlane   = {4{r_wdata[7:0]}};
                req_err = r_ctrl[2] & r_we;
            end
            3'b001, 3'b101: begin
                be      = r_off[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{r_wdata[15:0]}};
                req_err = r_off[0] | (r_ctrl[2] & r_we);
            end
            3'b010: begin
                be      = 4'b1111;
                req_err = (r_off != 2'b00);
            end
            default: req_err = 1'b1;
        endcase
    end

    assign ld_done = complete & ~r_we;
    assign st_done = complete & r_we & ~req_err;

    // Single-port synchronous array: byte-enabled write or word read on the completion edge.
    always_ff @(posedge CLK) begin
        if (!RST && st_done) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[r_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
        if (!RST && ld_done) rd_word <= mem[r_idx];
    end

    // Remember how to format the last load; an errored load (or reset) forces zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_zero <= 1'b1;
            ld_ctrl <= 3'b000;
            ld_off  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            err_q <= complete & req_err;
            if (ld_done) begin
                ld_zero <= req_err;
                ld_ctrl <= r_ctrl;
                ld_off  <= r_off;
            end
        end
    end

    // Lane select and sign/zero extension of the held read word.
    always_comb begin
        rd_b   = rd_word[{ld_off, 3'b000} +: 8];
        rd_h   = rd_word[{ld_off[1], 4'b0000} +: 16];
        ld_val = 32'd0;
        case (ld_ctrl)
            3'b000:  ld_val = {{24{rd_b[7]}}, rd_b};
            3'b100:  ld_val = {24'd0, rd_b};
            3'b001:  ld_val = {{16{rd_h[15]}}, rd_h};
            3'b101:  ld_val = {16'd0, rd_h};
            3'b010:  ld_val = rd_word;
            default: ld_val = 32'd0;
        endcase
    end

    assign bus.w_dram_odata = ld_zero ? 32'd0 : ld_val;
    assign bus.w_dram_busy  = (state == ACCESS);
    assign bus.w_dram_err   = err_q;

`ifdef DRAM_RESP_PERF_CNT_EN
    logic [31:0] rd_cnt, wr_cnt;

    // Count successful completions only; wrap naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
        end else begin
            if (ld_done && !req_err) rd_cnt <= rd_cnt + 32'd1;
            if (st_done)             wr_cnt <= wr_cnt + 32'd1;
        end
    end

    assign bus.w_dram_rd_cnt = rd_cnt;
    assign bus.w_dram_wr_cnt = wr_cnt;
`endif
endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed requests, byte-level reference model checked every cycle.
module tb_dram_responder;
    localparam int ADDR_W = 14;
    localparam int LAT    = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dram_responder_if bus();

    dram_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [int];
    bit          m_busy  = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_odata = 32'd0;
    int          m_edge  = 0;
    int          m_done  = 0;
    logic [31:0] m_rd = 32'd0, m_wr = 32'd0;
    logic [31:0] q_addr, q_wdata;
    logic [2:0]  q_ctrl;
    logic        q_we;

    task automatic model_complete();
        int          base, n;
        logic [1:0]  off;
        logic [31:0] v;
        bit          bad;
        off  = q_addr[1:0];
        base = int'((q_addr >> 2) & ((32'd1 << ADDR_W) - 1)) * 4;
        n    = (q_ctrl[1:0] == 2'b00) ? 1 : (q_ctrl[1:0] == 2'b01) ? 2 : 4;
        bad  = !(q_ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
               (q_ctrl[2] && q_we) || ((int'(off) % n) != 0);
        if (bad) begin
            m_err = 1'b1;
            if (!q_we) m_odata = 32'd0;
        end else if (q_we) begin
            for (int i = 0; i < n; i++) mb[base + int'(off) + i] = q_wdata[8*i +: 8];
            m_wr++;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                if (mb.exists(base + int'(off) + i))
                    v = v | (32'(mb[base + int'(off) + i]) << (8*i));
            end
            if (!q_ctrl[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            m_odata = v;
            m_rd++;
        end
    endtask

    // Model advances on every edge: accept when idle, finish LAT edges after acceptance.
    always @(posedge CLK) begin
        m_err = 1'b0;
        if (RST) begin
            m_busy  = 1'b0;
            m_odata = 32'd0;
            m_rd    = 32'd0;
            m_wr    = 32'd0;
        end else if (m_busy) begin
            if (m_edge == m_done) begin
                model_complete();
                m_busy = 1'b0;
            end
        end else if (bus.w_dram_le) begin
            q_addr  = bus.w_dram_addr;
            q_wdata = bus.w_dram_wdata;
            q_we    = bus.w_dram_we_t;
            q_ctrl  = bus.w_dram_ctrl;
            m_done  = m_edge + LAT;
            m_busy  = 1'b1;
        end
        m_edge++;
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy",  {31'd0, bus.w_dram_busy}, {31'd0, m_busy});
            check("err",   {31'd0, bus.w_dram_err},  {31'd0, m_err});
            check("odata", bus.w_dram_odata, m_odata);
`ifdef DRAM_RESP_PERF_CNT_EN
            check("rd_cnt", bus.w_dram_rd_cnt, m_rd);
            check("wr_cnt", bus.w_dram_wr_cnt, m_wr);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.w_dram_we_t  = we;
        bus.w_dram_ctrl  = ctrl;
        bus.w_dram_addr  = addr;
        bus.w_dram_wdata = wdata;
        bus.w_dram_le    = 1'b1;
        @(negedge CLK);
        bus.w_dram_le    = 1'b0;
    endtask

    task automatic wait_done(output int bc, output logic e);
        bc = 0;
        while (bus.w_dram_busy && bc < 300) begin
            bc++;
            @(negedge CLK);
        end
        if (bus.w_dram_busy) check("done_timeout", {31'd0, bus.w_dram_busy}, 32'd0);
        e = bus.w_dram_err;
    endtask

    task automatic run(input string name, input bit we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_odata, input bit exp_err);
        int   bc;
        logic e;
        issue(we, ctrl, addr, wdata);
        wait_done(bc, e);
        check({name, "_busycyc"}, 32'(bc), 32'(LAT));
        check({name, "_err"},     {31'd0, e}, {31'd0, exp_err});
        check({name, "_odata"},   bus.w_dram_odata, exp_odata);
    endtask

    initial begin
        int   bc;
        logic e;
        bus.w_dram_le    = 1'b0;
        bus.w_dram_addr  = 32'd0;
        bus.w_dram_wdata = 32'd0;
        bus.w_dram_we_t  = 1'b0;
        bus.w_dram_ctrl  = 3'b000;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_busy",  {31'd0, bus.w_dram_busy}, 32'd0);
        check("rst_err",   {31'd0, bus.w_dram_err},  32'd0);
        check("rst_odata", bus.w_dram_odata, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        //   name        we  ctrl    addr          wdata         odata after   err
        run("sw_100",    1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h00000000, 0);
        run("lw_100",    0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 0);
        run("sb_101",    1, 3'b000, 32'h101,      32'h5A,       32'hDEADBEEF, 0);
        run("lw_100b",   0, 3'b010, 32'h100,      32'h0,        32'hDEAD5AEF, 0);
        run("lb_101",    0, 3'b000, 32'h101,      32'h0,        32'h0000005A, 0);
        run("sb_102",    1, 3'b000, 32'h102,      32'h80,       32'h0000005A, 0);
        run("lb_102",    0, 3'b000, 32'h102,      32'h0,        32'hFFFFFF80, 0);
        run("lbu_102",   0, 3'b100, 32'h102,      32'h0,        32'h00000080, 0);
        run("lh_102",    0, 3'b001, 32'h102,      32'h0,        32'hFFFFDE80, 0);
        run("lhu_102",   0, 3'b101, 32'h102,      32'h0,        32'h0000DE80, 0);
        run("lh_103",    0, 3'b001, 32'h103,      32'h0,        32'h00000000, 1);
        run("lw_100c",   0, 3'b010, 32'h100,      32'h0,        32'hDE805AEF, 0);
        run("sw_104",    1, 3'b010, 32'h104,      32'h12345678, 32'hDE805AEF, 0);
        run("sh_106",    1, 3'b001, 32'h106,      32'h0000BEEF, 32'hDE805AEF, 0);
        run("lw_alias",  0, 3'b010, 32'h10104,    32'h0,        32'hBEEF5678, 0);
        run("lhu_104",   0, 3'b101, 32'h104,      32'h0,        32'h00005678, 0);
        run("sw_105",    1, 3'b010, 32'h105,      32'hAAAAAAAA, 32'h00005678, 1);
        run("lw_104",    0, 3'b010, 32'h104,      32'h0,        32'hBEEF5678, 0);
        run("sbu_104",   1, 3'b100, 32'h104,      32'h0,        32'hBEEF5678, 1);
        run("l011_104",  0, 3'b011, 32'h104,      32'h0,        32'h00000000, 1);
        run("lw_104b",   0, 3'b010, 32'h104,      32'h0,        32'hBEEF5678, 0);

        // le pulsed while busy with another address must be dropped.
        issue(0, 3'b010, 32'h100, 32'h0);
        issue(0, 3'b000, 32'h104, 32'h0);
        wait_done(bc, e);
        check("ign_odata", bus.w_dram_odata, 32'hDE805AEF);
        check("ign_err",   {31'd0, e}, 32'd0);
        // Issued in the first busy=0 cycle: must be accepted with no gap.
        run("b2b_lw_104", 0, 3'b010, 32'h104, 32'h0, 32'hBEEF5678, 0);

        // Reset in the 2nd busy cycle of a store aborts it.
        run("sw_200",    1, 3'b010, 32'h200,      32'h22222222, 32'hBEEF5678, 0);
        issue(1, 3'b010, 32'h200, 32'h11111111);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_busy",  {31'd0, bus.w_dram_busy}, 32'd0);
        check("abort_odata", bus.w_dram_odata, 32'd0);
        RST = 1'b0;
        run("lw_200",    0, 3'b010, 32'h200,      32'h0,        32'h22222222, 0);

        // Completion counters: 3 good loads, 2 good stores, 1 errored load.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        run("pc_lw",     0, 3'b010, 32'h200,      32'h0,        32'h22222222, 0);
        run("pc_lb",     0, 3'b000, 32'h101,      32'h0,        32'h0000005A, 0);
        run("pc_lh",     0, 3'b001, 32'h102,      32'h0,        32'hFFFFDE80, 0);
        run("pc_sw",     1, 3'b010, 32'h300,      32'h33333333, 32'hFFFFDE80, 0);
        run("pc_sb",     1, 3'b000, 32'h301,      32'h44,       32'hFFFFDE80, 0);
        run("pc_lherr",  0, 3'b001, 32'h103,      32'h0,        32'h00000000, 1);
`ifdef DRAM_RESP_PERF_CNT_EN
        check("pc_rd", bus.w_dram_rd_cnt, 32'd3);
        check("pc_wr", bus.w_dram_wr_cnt, 32'd2);
`endif
        RST = 1'b1;
        @(negedge CLK);
`ifdef DRAM_RESP_PERF_CNT_EN
        check("pc_rd_rst", bus.w_dram_rd_cnt, 32'd0);
        check("pc_wr_rst", bus.w_dram_wr_cnt, 32'd0);
`endif
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side responder for the shared DRAM interface that the bus arbiter drives on behalf of the granted core.
- Latches one request per le strobe, holds busy for a fixed access latency, then performs the access on an internal word array.
- Loads return data sign- or zero-extended per ctrl; stores are byte-lane merged.
- Acts as the simulation and FPGA BRAM stand-in for the DRAM controller behind the arbiter.

Parameters:
- ADDR_W, 14: word-address bits; the array holds 2**ADDR_W 32-bit words. Index is addr[ADDR_W+1:2]; upper address bits are ignored.
- LATENCY, 4: cycles busy stays high per access. Legal range is 1..255.

Ports:
- CLK  input  1  clock; all logic is on posedge.
- RST  input  1  reset, synchronous, active-high.
- w_dram_le  input  1  request strobe; sampled only in IDLE.
- w_dram_addr  input  32  byte address.
- w_dram_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- w_dram_we_t  input  1  1 = store, 0 = load.
- w_dram_ctrl  input  3  access size (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU. The U codes apply to loads only.
- w_dram_odata  output  32  load result, held until the next load completes.
- w_dram_busy  output  1  high while a request is in flight.
- w_dram_err  output  1  high for one cycle when a request completes with an error.

Behaviour:
- States are IDLE and ACCESS, plus an 8-bit countdown counter cnt.
- Reset:
  - state=IDLE, w_dram_busy=0, w_dram_odata=0, w_dram_err=0, cnt=0.
  - Array contents are not cleared.
  - Reset during ACCESS aborts the request with no array write.
  - Reset wins over le in the same cycle.
- IDLE, le=1 at edge T:
  - Latch addr, wdata, we_t and ctrl.
  - Set cnt=LATENCY-1, go to ACCESS.
  - busy=1 is registered, visible from T+1.
- ACCESS:
  - Decrement cnt each edge.
  - On the edge where cnt==0, perform the access, clear busy and return to IDLE.
  - busy is high for exactly LATENCY cycles (T+1..T+LATENCY); results are visible at T+LATENCY+1 together with busy=0.
- le is ignored while busy. No queuing, no error.
- A new le is accepted in the first cycle busy reads 0, giving back-to-back requests with zero idle cycles.
- Lane select uses off=addr[1:0].
- Load results:
  - B: byte off, sign-extended.
  - BU: byte off, zero-extended.
  - H: bytes off..off+1, sign-extended.
  - HU: same bytes, zero-extended.
  - W: whole word.
- Stores: B writes one byte lane; H writes two lanes; W writes all four. Other lanes are unchanged.
- Error conditions:
  - H/HU with off[0]=1.
  - W with off!=0.
  - Any undefined ctrl code (011, 110, 111), or a U code with we_t=1.
- On error:
  - No array write.
  - odata is set to 0 for loads and unchanged for stores.
  - w_dram_err=1 for the completion cycle only.
  - Latency is unchanged.
- odata updates only on a successful or failed load completion; stores leave it unchanged.
- A load issued after a store completes observes the stored value (no hazard window).
- The array is a single synchronous memory, sized for BRAM inference; read and write are both done on the completion edge.

Optional Feature:
- Macro: DRAM_RESP_PERF_CNT_EN.
- Defined:
  - Adds outputs w_dram_rd_cnt[31:0] and w_dram_wr_cnt[31:0].
  - Each increments by 1 on a successful load or store completion; errored requests are not counted.
  - Both reset to 0 on RST and wrap from 32'hFFFFFFFF to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Store W 0xDEADBEEF to addr 0x100 (ctrl=010, LATENCY=4): busy high for 4 cycles after le, err=0. Then load W 0x100 → odata=0xDEADBEEF at T+5 with busy=0.
- Store B 0x5A to 0x101, then load W 0x100 → 0xDEAD5AEF. Load B 0x101 → 0x0000005A. Store B 0x80 to 0x102, then load B 0x102 → 0xFFFFFF80 and load BU 0x102 → 0x00000080.
- Load H 0x102 after the above → 0xFFFFDE80. Load HU 0x102 → 0x0000DE80. Load H 0x103 → err pulse of 1 cycle, odata=0, memory unchanged.
- Pulse le during busy with a different addr → ignored, and the original access completes with its own data. Then issue le in the first busy=0 cycle → accepted with no gap.
- Assert RST at the 2nd busy cycle of store W 0x11111111 to 0x200 (0x200 pre-loaded with 0x22222222) → busy=0 the next cycle; a later load of 0x200 returns 0x22222222.
- With DRAM_RESP_PERF_CNT_EN: 3 good loads, 2 good stores and 1 errored load → rd_cnt=3, wr_cnt=2. RST → both 0.
